// File: rtl/mips_pkg.sv
// mips_pkg: constants and helpers shared by fetch, decode and hazard logic.
package mips_pkg;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic logic [31:0] jump_target(input logic [31:0] pcplus4, input logic [31:0] instr);
        return {pcplus4[31:28], instr[25:0], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-ROM, redirect and IF/ID signals between fetch and decode.
interface fetch_stage_if;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic        Stall;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] FetchCount;

    modport master (
        output ImemAddr, InstrD, PCPlus4D, ValidD, FetchCount,
        input  ImemRdata, Stall, PCSrcD, PCBranchD, JumpD
    );
    modport slave (
        input  ImemAddr, InstrD, PCPlus4D, ValidD, FetchCount,
        output ImemRdata, Stall, PCSrcD, PCBranchD, JumpD
    );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register with hold enable, bubble clear and async active-low reset.
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcplus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);
    logic [31:0] instr_q, instr_d, pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    // Hold beats clear, so a redirect seen during a stall is not lost.
    always_comb begin
        instr_d   = !en_i ? instr_q   : clr_i ? NOP_INSTR : instr_i;
        pcplus4_d = !en_i ? pcplus4_q : clr_i ? '0        : pcplus4_i;
        valid_d   = !en_i ? valid_q   : !clr_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID capture for mips_pipeline.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    logic [31:0] pc_q, pc_d, cnt_q, cnt_d, pc_plus4, instr_q, pcplus4_q;
    logic        valid_q, redirect;

    // Redirect requests only count when IF/ID holds a real instruction.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        redirect = valid_q & (bus.PCSrcD | bus.JumpD);
        pc_d     = bus.Stall ? pc_q
                 : redirect  ? (bus.PCSrcD ? bus.PCBranchD : jump_target(pcplus4_q, instr_q))
                 : pc_plus4;
        cnt_d    = (bus.Stall | redirect) ? cnt_q : cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    ifid_reg u_ifid (
        .clk       (clk),
        .reset     (reset),
        .en_i      (~bus.Stall),
        .clr_i     (redirect),
        .instr_i   (bus.ImemRdata),
        .pcplus4_i (pc_plus4),
        .instr_o   (instr_q),
        .pcplus4_o (pcplus4_q),
        .valid_o   (valid_q)
    );

    assign bus.ImemAddr   = pc_q;
    assign bus.InstrD     = instr_q;
    assign bus.PCPlus4D   = pcplus4_q;
    assign bus.ValidD     = valid_q;
    assign bus.FetchCount = cnt_q;
endmodule
